// File: rtl/traffic_override_ctrl_pkg.sv
// ============================================================================
// Module  : traffic_pkg
// Brief   : Shared types and index constants for the traffic override block.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package traffic_pkg;

  // Two-state mode FSM: IDLE (automatic) or SELECT (manual channel chosen).
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SELECT = 1'b1
  } state_t;

  // Push-button roles within the btn bus.
  localparam int BTN_CLR_ALL  = 0;
  localparam int BTN_SET      = 1;
  localparam int BTN_CLR_SEL  = 2;
  localparam int NUM_BTN_USED = 3;

  // Light channel indices.
  localparam int CH_RED = 0;
  localparam int CH_YEL = 1;
  localparam int CH_GRN = 2;

endpackage

`default_nettype wire

// File: rtl/traffic_override_ctrl_if.sv
// ============================================================================
// Module  : traffic_override_ctrl_if
// Brief   : Operator inputs and override status bundle for the controller.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface traffic_override_ctrl_if #(
  parameter int NUM_CH = 3,
  parameter int SW_W   = 2
);
  logic [SW_W-1:0]   sw;
  logic [3:0]        btn;
  logic [NUM_CH-1:0] override_q;
  logic              manual_active;
  logic [2:0]        sel_ch;
  logic              evt_pulse;

  // Operator / stimulus side drives the switches and buttons.
  modport master (
    output sw, btn,
    input  override_q, manual_active, sel_ch, evt_pulse
  );

  // Controller side consumes inputs and publishes status.
  modport slave (
    input  sw, btn,
    output override_q, manual_active, sel_ch, evt_pulse
  );
endinterface

`default_nettype wire

// File: rtl/traffic_override_ctrl_btn_debounce.sv
// ============================================================================
// Module  : btn_debounce
// Brief   : 2-flop synchronizer, stable-level debounce and rising-edge press
//           detector for one asynchronous push button.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module btn_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int               c_CNT_W    = $clog2(DEBOUNCE_CYC);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYC - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic [1:0]         r_vld;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_level;
  logic               r_armed;
  logic               r_press;
  logic               w_differs;
  logic               w_accept;

  assign w_differs = (r_sync2 != r_level);
  assign w_accept  = w_differs && (r_cnt == c_CNT_LAST);
  assign o_press   = r_press;

  // Two-flop synchronizer; r_vld marks when r_sync2 holds a real sample
  // rather than its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_vld   <= 2'b00;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_vld   <= {r_vld[0], 1'b1};
    end
  end

  // Accept a new level only after DEBOUNCE_CYC consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (!w_differs) begin
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_level <= r_sync2;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // Press pulse on a debounced rise; arming requires a genuinely low sample
  // so a button held through reset never produces a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
      r_press <= 1'b0;
    end else begin
      if (r_vld[1] && !r_sync2) begin
        r_armed <= 1'b1;
      end
      r_press <= w_accept && r_sync2 && r_armed;
    end
  end

endmodule

`default_nettype wire

// File: rtl/traffic_override_ctrl.sv
// ============================================================================
// Module  : traffic_override_ctrl
// Brief   : Manual per-channel traffic-light override with debounced buttons,
//           mode select FSM and auto-clear hold timer.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module traffic_override_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_CH       = 3,
  parameter int SW_W         = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int HOLD_CYC     = 1000,
  parameter int EXCLUSIVE    = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  traffic_override_ctrl_if.slave   bus
);

  logic [SW_W-1:0]         r_sw_s1;
  logic [SW_W-1:0]         r_sw_s2;
  logic [NUM_BTN_USED-1:0] w_press;
  state_t                  r_state;
  logic                    r_manual;
  logic [2:0]              r_sel_ch;
  logic [NUM_CH-1:0]       r_override;
  logic                    r_evt;
  logic [NUM_CH-1:0]       w_sel_mask;
  logic                    w_sel_next;
  logic                    w_in_sel;
  logic                    w_clr_all;
  logic                    w_clr_sel_acc;
  logic                    w_set_acc;
  logic                    w_expire;
  logic                    w_unused_btn3;

  // Mode switch synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= bus.sw;
      r_sw_s2 <= r_sw_s1;
    end
  end

  for (genvar gi = 0; gi < NUM_BTN_USED; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn   (bus.btn[gi]),
      .o_press (w_press[gi])
    );
  end

  assign w_unused_btn3 = bus.btn[3];

  // SELECT whenever the synchronized switch names a real channel.
  assign w_sel_next = (r_sw_s2 != '0) && (r_sw_s2 <= SW_W'(NUM_CH));
  // Channel presses only act while selected now and staying selected.
  assign w_in_sel   = (r_state == ST_SELECT) && w_sel_next;
  assign w_sel_mask = NUM_CH'(1) << r_sel_ch;

  // Priority: clear-all > clear-selected > set.
  assign w_clr_all     = w_press[BTN_CLR_ALL];
  assign w_clr_sel_acc = w_in_sel && w_press[BTN_CLR_SEL] && !w_clr_all;
  assign w_set_acc     = w_in_sel && w_press[BTN_SET] && !w_clr_all
                         && !w_press[BTN_CLR_SEL];

  // Mode FSM with registered manual_active / sel_ch outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_manual <= 1'b0;
      r_sel_ch <= '0;
    end else if (w_sel_next) begin
      r_state  <= ST_SELECT;
      r_manual <= 1'b1;
      r_sel_ch <= 3'(r_sw_s2 - 1'b1);
    end else begin
      r_state  <= ST_IDLE;
      r_manual <= 1'b0;
      r_sel_ch <= '0;
    end
  end

  if (HOLD_CYC > 0) begin : g_hold
    localparam int                  c_HOLD_W    = $clog2(HOLD_CYC + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLD_CYC);
    logic [c_HOLD_W-1:0] r_hold;

    // Expires when the last count is consumed; a press that was given
    // precedence leaves the counter at 0 so expiry follows next cycle.
    assign w_expire = (r_override != '0) && (r_hold <= c_HOLD_W'(1));

    // Hold countdown: reload on accepted set, saturate at zero.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_hold <= '0;
      end else if (w_set_acc) begin
        r_hold <= c_HOLD_LOAD;
      end else if ((r_override != '0) && (r_hold != '0)) begin
        r_hold <= r_hold - 1'b1;
      end
    end
  end else begin : g_no_hold
    assign w_expire = 1'b0;
  end

  // Override flags and event pulse; presses outrank the timeout, and a
  // fall back to IDLE clears silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_override <= '0;
      r_evt      <= 1'b0;
    end else begin
      r_evt <= w_clr_all || w_clr_sel_acc || w_set_acc || w_expire;
      if (w_clr_all) begin
        r_override <= '0;
      end else if (w_clr_sel_acc) begin
        r_override <= r_override & ~w_sel_mask;
      end else if (w_set_acc) begin
        r_override <= (EXCLUSIVE != 0) ? w_sel_mask : (r_override | w_sel_mask);
      end else if (w_expire || !w_sel_next) begin
        r_override <= '0;
      end
    end
  end

  assign bus.override_q    = r_override;
  assign bus.manual_active = r_manual;
  assign bus.sel_ch        = r_sel_ch;
  assign bus.evt_pulse     = r_evt;

endmodule

`default_nettype wire
